// File: rtl/masked_share_encoder.sv
// Masking front-end: splits plain operands A and B into two Boolean shares each
// using masks drawn from an internal 16-bit Galois LFSR, plus refresh randomness rN.
module masked_share_encoder #(
   parameter int unsigned W = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          seed_load,
   input  logic [15:0]   seed_val,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_A,
   input  logic [W-1:0]  in_B,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  o_A0,
   output logic [W-1:0]  o_A1,
   output logic [W-1:0]  o_B0,
   output logic [W-1:0]  o_B1,
   output logic [W-1:0]  o_rN,
   output logic [15:0]   o_count
);

   if (W < 1 || 3 * W > 16) begin : g_bad_width
      $error("masked_share_encoder: W must satisfy 1 <= W and 3*W <= 16");
   end

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic {
      UNSEEDED = 1'b0,
      RUN      = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  a0_q, a0_d, a1_q, a1_d;
   logic [W-1:0]  b0_q, b0_d, b1_q, b1_d;
   logic [W-1:0]  rn_q, rn_d;
   logic [15:0]   count_q, count_d;

   logic          seed_ok;
   logic          accept;
   logic [W-1:0]  m_a, m_b, m_r;

   always_comb begin
      seed_ok  = seed_load && (seed_val != 16'h0000);
      in_ready = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
      accept   = in_valid && in_ready;
      m_a      = lfsr_q[W-1:0];
      m_b      = lfsr_q[2*W-1:W];
      m_r      = lfsr_q[3*W-1:2*W];

      state_d     = state_q;
      lfsr_d      = lfsr_q;
      out_valid_d = out_valid_q;
      a0_d        = a0_q;
      a1_d        = a1_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      rn_d        = rn_q;
      count_d     = count_q;

      // accept and seed_load are mutually exclusive because in_ready masks seed_load
      if (accept) begin
         a0_d        = in_A ^ m_a;
         a1_d        = m_a;
         b0_d        = in_B ^ m_b;
         b1_d        = m_b;
         rn_d        = m_r;
         out_valid_d = 1'b1;
         count_d     = count_q + 16'd1;
         lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (seed_ok) begin
         lfsr_d  = seed_val;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= UNSEEDED;
         lfsr_q      <= '0;
         out_valid_q <= 1'b0;
         a0_q        <= '0;
         a1_q        <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         rn_q        <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         out_valid_q <= out_valid_d;
         a0_q        <= a0_d;
         a1_q        <= a1_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         rn_q        <= rn_d;
         count_q     <= count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign o_A0      = a0_q;
   assign o_A1      = a1_q;
   assign o_B0      = b0_q;
   assign o_B1      = b1_q;
   assign o_rN      = rn_q;
   assign o_count   = count_q;

endmodule

// File: tb/tb_masked_share_encoder.sv
// Scoreboard bench for masked_share_encoder (W=4): driver predicts each accepted
// transaction from a reference LFSR model; a negedge monitor checks every transfer.
module tb_masked_share_encoder;

   localparam int unsigned W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          seed_load = 1'b0;
   logic [15:0]   seed_val = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_A = '0;
   logic [W-1:0]  in_B = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  o_A0, o_A1, o_B0, o_B1, o_rN;
   logic [15:0]   o_count;

   masked_share_encoder #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_val(seed_val),
      .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
      .out_valid(out_valid), .out_ready(out_ready),
      .o_A0(o_A0), .o_A1(o_A1), .o_B0(o_B0), .o_B1(o_B1), .o_rN(o_rN),
      .o_count(o_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  a0, a1, b0, b1, rn, a, b;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_run = 0;
   logic [15:0] m_lfsr = '0;
   bit          m_ov = 0;
   logic [15:0] m_cnt = '0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic [15:0] n;
      n = {1'b0, l[15:1]};
      if (l[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // called at posedge+1: drives one cycle, predicts, returns at next posedge+1
   task automatic step(input logic rst, input logic sl, input logic [15:0] sv,
                       input logic iv, input logic [3:0] a, input logic [3:0] b,
                       input logic ordy);
      bit   m_ready;
      exp_t e;
      rst_n = rst; seed_load = sl; seed_val = sv;
      in_valid = iv; in_A = a; in_B = b; out_ready = ordy;
      #2;
      m_ready = m_run && !sl && (!m_ov || ordy);
      if (rst) chk("in_ready", {15'd0, in_ready}, {15'd0, m_ready});
      if (!rst) begin
         m_run = 0; m_lfsr = '0; m_ov = 0; m_cnt = '0;
      end else begin
         if (iv && m_ready) begin
            m_cnt = m_cnt + 16'd1;
            e.a1 = m_lfsr[3:0];  e.a0 = a ^ m_lfsr[3:0];
            e.b1 = m_lfsr[7:4];  e.b0 = b ^ m_lfsr[7:4];
            e.rn = m_lfsr[11:8]; e.a = a; e.b = b; e.cnt = m_cnt;
            sb.push_back(e);
            m_lfsr = lfsr_step(m_lfsr);
            m_ov = 1;
         end else if (ordy) begin
            m_ov = 0;
         end
         if (sl && sv != 16'h0000) begin
            m_lfsr = sv;
            m_run = 1;
         end
      end
      @(posedge clk);
      #1;
      if (!rst) sb.delete();
   endtask

   task automatic chk_outs(input string tag, input logic v, input logic [3:0] a0,
                           input logic [3:0] a1, input logic [3:0] b0,
                           input logic [3:0] b1, input logic [3:0] rn,
                           input logic [15:0] cnt);
      chk({tag, "_valid"}, {15'd0, out_valid}, {15'd0, v});
      chk({tag, "_A0"}, {12'd0, o_A0}, {12'd0, a0});
      chk({tag, "_A1"}, {12'd0, o_A1}, {12'd0, a1});
      chk({tag, "_B0"}, {12'd0, o_B0}, {12'd0, b0});
      chk({tag, "_B1"}, {12'd0, o_B1}, {12'd0, b1});
      chk({tag, "_rN"}, {12'd0, o_rN}, {12'd0, rn});
      chk({tag, "_count"}, o_count, cnt);
   endtask

   // monitor: every transfer (out_valid && out_ready) consumes one expected entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: count %h with empty scoreboard", o_count);
            end else begin
               e = sb.pop_front();
               chk("sb_A0", {12'd0, o_A0}, {12'd0, e.a0});
               chk("sb_A1", {12'd0, o_A1}, {12'd0, e.a1});
               chk("sb_B0", {12'd0, o_B0}, {12'd0, e.b0});
               chk("sb_B1", {12'd0, o_B1}, {12'd0, e.b1});
               chk("sb_rN", {12'd0, o_rN}, {12'd0, e.rn});
               chk("sb_count", o_count, e.cnt);
               chk("xor_A", {12'd0, o_A0 ^ o_A1}, {12'd0, e.a});
               chk("xor_B", {12'd0, o_B0 ^ o_B1}, {12'd0, e.b});
            end
         end
      end
   end

   initial begin
      logic [15:0] sv;
      @(posedge clk);
      #1;
      step(0, 0, 16'h0, 0, 4'h0, 4'h0, 0);
      step(0, 0, 16'h0, 0, 4'h0, 4'h0, 0);
      chk_outs("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);

      // unseeded: nothing is accepted
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 16'h0, 1, 4'h5, 4'h3, 1);
         chk("unseeded_valid", {15'd0, out_valid}, 16'h0);
         chk("unseeded_count", o_count, 16'h0);
      end

      // zero seed is ignored, ACE1 seeds
      step(1, 1, 16'h0000, 0, 4'h0, 4'h0, 1);
      step(1, 0, 16'h0000, 0, 4'h0, 4'h0, 1);
      step(1, 1, 16'hACE1, 0, 4'h0, 4'h0, 1);

      step(1, 0, 16'h0, 1, 4'h5, 4'h3, 1);
      chk_outs("first", 1, 4'h4, 4'h1, 4'hD, 4'hE, 4'hC, 16'd1);
      step(1, 0, 16'h0, 1, 4'h5, 4'h3, 1);
      chk_outs("second", 1, 4'h5, 4'h0, 4'h4, 4'h7, 4'h2, 16'd2);

      // backpressure: outputs and lfsr frozen
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 16'h0, 1, 4'($urandom), 4'($urandom), 0);
         chk_outs("hold", 1, 4'h5, 4'h0, 4'h4, 4'h7, 4'h2, 16'd2);
      end
      step(1, 0, 16'h0, 1, 4'h9, 4'h6, 1);
      chk_outs("resume", 1, 4'h1, 4'h8, 4'h5, 4'h3, 4'h1, 16'd3);

      // drain without accept keeps share values
      step(1, 0, 16'h0, 0, 4'h0, 4'h0, 1);
      chk_outs("drain", 0, 4'h1, 4'h8, 4'h5, 4'h3, 4'h1, 16'd3);

      // randomized run with a mid-run reset
      for (int i = 0; i < 1200; i++) begin
         if (i == 600) begin
            step(0, 0, 16'h0, 1, 4'($urandom), 4'($urandom), 0);
            chk_outs("midreset", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
            step(1, 1, 16'(($urandom % 16'hFFFF) + 1), 0, 4'h0, 4'h0, 1);
         end else begin
            sv = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            step(1, ($urandom_range(0, 40) == 0), sv,
                 ($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0));
         end
      end

      // drain everything still in flight
      for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0, 4'h0, 4'h0, 1);
      chk("sb_empty", 16'(sb.size()), 16'h0);
      chk("final_valid", {15'd0, out_valid}, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
